// File: rtl/uriscv_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uriscv_fetch_pkg
// Description : Shared reset vector, fetch state encodings and PC helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package uriscv_fetch_pkg;

    localparam logic [31:0] c_RESET_VECTOR = 32'h0000_2000;

    localparam logic [1:0] c_ST_REQ   = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;
    localparam logic [1:0] c_ST_FAULT = 2'd3;

    typedef enum logic [1:0] {
        ST_REQ   = c_ST_REQ,
        ST_WAIT  = c_ST_WAIT,
        ST_HOLD  = c_ST_HOLD,
        ST_FAULT = c_ST_FAULT
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uriscv_fetch.sv
`default_nettype none
// ============================================================================
// Module      : uriscv_fetch
// Description : Single-outstanding instruction fetch with one-entry buffer
//               and branch redirect handling.
// Revision    : 1.0 - initial release
// ============================================================================
module uriscv_fetch
    import uriscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = c_RESET_VECTOR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_request_i,
    input  logic [31:0] branch_pc_i,
    output logic        mem_rd_o,
    output logic [31:0] mem_pc_o,
    input  logic        mem_accept_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_inst_i,
    input  logic        mem_error_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    output logic        fetch_fault_o,
    input  logic        fetch_accept_i
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    fetch_state_t w_redirect_state;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  r_req_pc;
    logic [31:0]  w_req_pc_next;
    logic         r_drop;
    logic         w_drop_next;
    logic         w_buf_load;
    logic [31:0]  r_buf_instr;
    logic [31:0]  r_buf_pc;
    logic         r_buf_fault;

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_req_pc_next    = r_req_pc;
        w_drop_next      = r_drop;
        w_buf_load       = 1'b0;
        w_redirect_state = is_misaligned(branch_pc_i) ? ST_FAULT : ST_REQ;

        case (r_state)
            ST_REQ: begin
                if (branch_request_i) begin
                    w_pc_next = branch_pc_i;
                    if (mem_accept_i) begin
                        // Old-path request already on the bus: swallow its response.
                        w_state_next = ST_WAIT;
                        w_drop_next  = 1'b1;
                    end else begin
                        w_state_next = w_redirect_state;
                    end
                end else if (mem_accept_i) begin
                    w_req_pc_next = r_pc;
                    w_pc_next     = r_pc + 32'd4;
                    w_state_next  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (branch_request_i) begin
                    w_pc_next = branch_pc_i;
                    if (mem_valid_i) begin
                        w_drop_next  = 1'b0;
                        w_state_next = w_redirect_state;
                    end else begin
                        w_drop_next  = 1'b1;
                    end
                end else if (mem_valid_i) begin
                    if (r_drop) begin
                        // A misaligned redirect target waits here for the stale response.
                        w_drop_next  = 1'b0;
                        w_state_next = is_misaligned(r_pc) ? ST_FAULT : ST_REQ;
                    end else begin
                        w_buf_load   = 1'b1;
                        w_state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD, ST_FAULT: begin
                if (branch_request_i) begin
                    w_pc_next    = branch_pc_i;
                    w_state_next = w_redirect_state;
                end else if (fetch_accept_i) begin
                    w_state_next = ST_REQ;
                end
            end
            default: w_state_next = ST_REQ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_REQ;
            r_pc        <= RESET_VECTOR;
            r_req_pc    <= 32'd0;
            r_drop      <= 1'b0;
            r_buf_instr <= 32'd0;
            r_buf_pc    <= 32'd0;
            r_buf_fault <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_req_pc <= w_req_pc_next;
            r_drop   <= w_drop_next;
            if (w_buf_load) begin
                r_buf_instr <= mem_error_i ? 32'd0 : mem_inst_i;
                r_buf_pc    <= r_req_pc;
                r_buf_fault <= mem_error_i;
            end
        end
    end

    always_comb begin
        mem_rd_o      = 1'b0;
        mem_pc_o      = r_pc;
        fetch_valid_o = 1'b0;
        fetch_instr_o = 32'd0;
        fetch_pc_o    = 32'd0;
        fetch_fault_o = 1'b0;
        if (!rst_i) begin
            case (r_state)
                ST_REQ: mem_rd_o = 1'b1;
                ST_HOLD: begin
                    fetch_valid_o = 1'b1;
                    fetch_instr_o = r_buf_instr;
                    fetch_pc_o    = r_buf_pc;
                    fetch_fault_o = r_buf_fault;
                end
                ST_FAULT: begin
                    fetch_valid_o = 1'b1;
                    fetch_pc_o    = r_pc;
                    fetch_fault_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
